// File: rtl/issue_queue_int_pkg.sv
// Shared widths, entry record and wakeup helper for the integer issue queue.
package issue_queue_int_pkg;

    localparam int unsigned IQ_TAG_WIDTH  = 6;
    localparam int unsigned IQ_OPC_WIDTH  = 4;
    localparam int unsigned IQ_DATA_WIDTH = 32;

    typedef struct packed {
        logic                     busy;
        logic [IQ_OPC_WIDTH-1:0]  opcode;
        logic [IQ_TAG_WIDTH-1:0]  rd_tag;
        logic [IQ_DATA_WIDTH-1:0] rs1_data;
        logic [IQ_TAG_WIDTH-1:0]  rs1_tag;
        logic                     rs1_valid;
        logic [IQ_DATA_WIDTH-1:0] rs2_data;
        logic [IQ_TAG_WIDTH-1:0]  rs2_tag;
        logic                     rs2_valid;
    } iq_entry_t;

    // Capture a CDB broadcast into any still-waiting operand of a live entry.
    function automatic iq_entry_t iq_wakeup(
        input iq_entry_t                e,
        input logic                     cdb_valid,
        input logic [IQ_TAG_WIDTH-1:0]  cdb_tag,
        input logic [IQ_DATA_WIDTH-1:0] cdb_data
    );
        iq_entry_t w;
        w = e;
        if (e.busy && cdb_valid && !e.rs1_valid && (e.rs1_tag == cdb_tag)) begin
            w.rs1_data  = cdb_data;
            w.rs1_valid = 1'b1;
        end
        if (e.busy && cdb_valid && !e.rs2_valid && (e.rs2_tag == cdb_tag)) begin
            w.rs2_data  = cdb_data;
            w.rs2_valid = 1'b1;
        end
        return w;
    endfunction

endpackage

// File: rtl/iq_select.sv
// Oldest-first priority select: lowest-index ready entry wins.
module iq_select #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [DEPTH-1:0] ready,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from youngest to oldest so the oldest ready entry is the last write.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (ready[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_queue_int.sv
// Age-ordered integer issue queue with CDB wakeup and oldest-first issue.
module issue_queue_int
    import issue_queue_int_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = IQ_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = IQ_TAG_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatch_en_integer,
    input  logic [IQ_OPC_WIDTH-1:0] dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]    dispatch_rd_tag,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs1_data,
    input  logic [DATA_WIDTH-1:0]   dispatch_rs2_data,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs1_tag,
    input  logic [TAG_WIDTH-1:0]    dispatch_rs2_tag,
    input  logic                    dispatch_rs1_valid,
    input  logic                    dispatch_rs2_valid,
    input  logic [TAG_WIDTH-1:0]    CDB_tag,
    input  logic                    CDB_valid,
    input  logic [DATA_WIDTH-1:0]   CDB_data,
    input  logic                    issue_ready,
    output logic                    issueque_full_integer,
    output logic                    issue_valid,
    output logic [IQ_OPC_WIDTH-1:0] issue_opcode,
    output logic [TAG_WIDTH-1:0]    issue_rd_tag,
    output logic [DATA_WIDTH-1:0]   issue_rs1_data,
    output logic [DATA_WIDTH-1:0]   issue_rs2_data
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    iq_entry_t [DEPTH-1:0] entries;
    iq_entry_t [DEPTH-1:0] entries_nxt;
    iq_entry_t [DEPTH-1:0] woken;
    iq_entry_t             disp_entry;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic [CNT_W-1:0]      count_after_issue;
    logic [DEPTH-1:0]      ready;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;
    logic                  do_issue;
    logic                  do_disp;

    assign issueque_full_integer = (count == CNT_W'(DEPTH));
    assign do_issue              = sel_found & issue_ready;
    assign do_disp               = dispatch_en_integer & ~issueque_full_integer;

    // Readiness of each held entry from registered state only.
    always_comb begin
        ready = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ready[i] = entries[i].busy & entries[i].rs1_valid & entries[i].rs2_valid;
        end
    end

    iq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .ready (ready),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Present the selected entry; zero fields when nothing is ready.
    always_comb begin
        issue_valid    = sel_found;
        issue_opcode   = '0;
        issue_rd_tag   = '0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        if (sel_found) begin
            issue_opcode   = entries[sel_idx].opcode;
            issue_rd_tag   = entries[sel_idx].rd_tag;
            issue_rs1_data = entries[sel_idx].rs1_data;
            issue_rs2_data = entries[sel_idx].rs2_data;
        end
    end

    // Apply this cycle's CDB broadcast to held entries and the incoming one.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            woken[i] = iq_wakeup(entries[i], CDB_valid, CDB_tag, CDB_data);
        end
        disp_entry           = '0;
        disp_entry.busy      = 1'b1;
        disp_entry.opcode    = dispatch_opcode;
        disp_entry.rd_tag    = dispatch_rd_tag;
        disp_entry.rs1_data  = dispatch_rs1_data;
        disp_entry.rs1_tag   = dispatch_rs1_tag;
        disp_entry.rs1_valid = dispatch_rs1_valid;
        disp_entry.rs2_data  = dispatch_rs2_data;
        disp_entry.rs2_tag   = dispatch_rs2_tag;
        disp_entry.rs2_valid = dispatch_rs2_valid;
        disp_entry           = iq_wakeup(disp_entry, CDB_valid, CDB_tag, CDB_data);
    end

    // Compact over the issued slot, then append the dispatch at the new tail.
    always_comb begin
        count_after_issue = count - CNT_W'(do_issue);
        entries_nxt       = woken;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (do_issue && (i >= int'(sel_idx))) begin
                entries_nxt[i] = woken[i+1];
            end
        end
        if (do_issue) begin
            entries_nxt[DEPTH-1] = '0;
        end
        if (do_disp) begin
            entries_nxt[IDX_W'(count_after_issue)] = disp_entry;
        end
        count_nxt = count_after_issue + CNT_W'(do_disp);
    end

    // State registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries <= '0;
            count   <= '0;
        end else begin
            entries <= entries_nxt;
            count   <= count_nxt;
        end
    end

endmodule

// File: tb/tb_issue_queue_int.sv
// Directed self-checking bench for issue_queue_int.
module tb_issue_queue_int;

    logic        clk;
    logic        reset;
    logic        dispatch_en_integer;
    logic [3:0]  dispatch_opcode;
    logic [5:0]  dispatch_rd_tag;
    logic [31:0] dispatch_rs1_data;
    logic [31:0] dispatch_rs2_data;
    logic [5:0]  dispatch_rs1_tag;
    logic [5:0]  dispatch_rs2_tag;
    logic        dispatch_rs1_valid;
    logic        dispatch_rs2_valid;
    logic [5:0]  CDB_tag;
    logic        CDB_valid;
    logic [31:0] CDB_data;
    logic        issue_ready;
    logic        issueque_full_integer;
    logic        issue_valid;
    logic [3:0]  issue_opcode;
    logic [5:0]  issue_rd_tag;
    logic [31:0] issue_rs1_data;
    logic [31:0] issue_rs2_data;

    int checks = 0;
    int errors = 0;

    issue_queue_int dut (
        .clk                   (clk),
        .reset                 (reset),
        .dispatch_en_integer   (dispatch_en_integer),
        .dispatch_opcode       (dispatch_opcode),
        .dispatch_rd_tag       (dispatch_rd_tag),
        .dispatch_rs1_data     (dispatch_rs1_data),
        .dispatch_rs2_data     (dispatch_rs2_data),
        .dispatch_rs1_tag      (dispatch_rs1_tag),
        .dispatch_rs2_tag      (dispatch_rs2_tag),
        .dispatch_rs1_valid    (dispatch_rs1_valid),
        .dispatch_rs2_valid    (dispatch_rs2_valid),
        .CDB_tag               (CDB_tag),
        .CDB_valid             (CDB_valid),
        .CDB_data              (CDB_data),
        .issue_ready           (issue_ready),
        .issueque_full_integer (issueque_full_integer),
        .issue_valid           (issue_valid),
        .issue_opcode          (issue_opcode),
        .issue_rd_tag          (issue_rd_tag),
        .issue_rs1_data        (issue_rs1_data),
        .issue_rs2_data        (issue_rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic en, input logic [3:0] opc, input logic [5:0] rd,
                        input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                        input logic [31:0] d2, input logic [5:0] t2, input logic v2);
        dispatch_en_integer = en;
        dispatch_opcode     = opc;
        dispatch_rd_tag     = rd;
        dispatch_rs1_data   = d1;
        dispatch_rs1_tag    = t1;
        dispatch_rs1_valid  = v1;
        dispatch_rs2_data   = d2;
        dispatch_rs2_tag    = t2;
        dispatch_rs2_valid  = v2;
    endtask

    task automatic cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
        CDB_valid = v;
        CDB_tag   = t;
        CDB_data  = d;
    endtask

    initial begin
        reset       = 1'b1;
        issue_ready = 1'b0;
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        cdb(1'b0, 6'd0, 32'd0);

        // Reset state
        step();
        step();
        chk("rst_full", 32'(issueque_full_integer), 32'd0);
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_opcode", 32'(issue_opcode), 32'd0);
        chk("rst_rd_tag", 32'(issue_rd_tag), 32'd0);
        chk("rst_rs1", issue_rs1_data, 32'd0);
        chk("rst_rs2", issue_rs2_data, 32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_valid", 32'(issue_valid), 32'd0);

        // Single ready dispatch issues the next cycle
        issue_ready = 1'b1;
        disp(1'b1, 4'h1, 6'd5, 32'd10, 6'd0, 1'b1, 32'd20, 6'd0, 1'b1);
        step();
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        chk("t1_valid", 32'(issue_valid), 32'd1);
        chk("t1_opcode", 32'(issue_opcode), 32'h1);
        chk("t1_rd_tag", 32'(issue_rd_tag), 32'd5);
        chk("t1_rs1", issue_rs1_data, 32'd10);
        chk("t1_rs2", issue_rs2_data, 32'd20);
        step();
        chk("t1_drained", 32'(issue_valid), 32'd0);

        // Waiting operand woken by CDB; a wrong tag must not wake it
        disp(1'b1, 4'h2, 6'd6, 32'd0, 6'd9, 1'b0, 32'd3, 6'd0, 1'b1);
        step();
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        chk("t2_wait", 32'(issue_valid), 32'd0);
        cdb(1'b1, 6'd8, 32'h1234);
        step();
        chk("t2_wrong_tag", 32'(issue_valid), 32'd0);
        cdb(1'b1, 6'd9, 32'hDEAD);
        step();
        cdb(1'b0, 6'd0, 32'd0);
        chk("t2_woken_valid", 32'(issue_valid), 32'd1);
        chk("t2_rs1", issue_rs1_data, 32'hDEAD);
        chk("t2_rs2", issue_rs2_data, 32'd3);
        chk("t2_rd_tag", 32'(issue_rd_tag), 32'd6);
        step();
        chk("t2_drained", 32'(issue_valid), 32'd0);

        // Fill, overflow dispatch ignored, drain in age order with one refill
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(1'b1, 4'(i + 3), 6'(10 + i), 32'(100 + i), 6'd0, 1'b1, 32'(200 + i), 6'd0, 1'b1);
            step();
            if (i == 2) chk("t3_not_full_3", 32'(issueque_full_integer), 32'd0);
        end
        chk("t3_full_4", 32'(issueque_full_integer), 32'd1);
        disp(1'b1, 4'h7, 6'd14, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
        step();
        chk("t3_full_hold", 32'(issueque_full_integer), 32'd1);
        chk("t3_head_tag", 32'(issue_rd_tag), 32'd10);
        chk("t3_head_rs1", issue_rs1_data, 32'd100);
        // Full and issuing this cycle: dispatch of tag 15 still rejected
        issue_ready = 1'b1;
        disp(1'b1, 4'h7, 6'd15, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
        step();
        chk("t3_after_10", 32'(issue_rd_tag), 32'd11);
        chk("t3_not_full", 32'(issueque_full_integer), 32'd0);
        // Issue of 11 together with dispatch of 20
        disp(1'b1, 4'h9, 6'd20, 32'd300, 6'd0, 1'b1, 32'd400, 6'd0, 1'b1);
        step();
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        chk("t3_after_11", 32'(issue_rd_tag), 32'd12);
        chk("t3_cnt_same", 32'(issueque_full_integer), 32'd0);
        step();
        chk("t3_after_12", 32'(issue_rd_tag), 32'd13);
        step();
        chk("t3_after_13", 32'(issue_rd_tag), 32'd20);
        chk("t3_tail_opc", 32'(issue_opcode), 32'h9);
        chk("t3_tail_rs2", issue_rs2_data, 32'd400);
        step();
        chk("t3_empty", 32'(issue_valid), 32'd0);

        // Younger ready entry bypasses an older waiting one
        issue_ready = 1'b0;
        disp(1'b1, 4'h4, 6'd30, 32'd0, 6'd3, 1'b0, 32'd5, 6'd0, 1'b1);
        step();
        disp(1'b1, 4'h5, 6'd31, 32'd7, 6'd0, 1'b1, 32'd8, 6'd0, 1'b1);
        step();
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        chk("t4_sel_young", 32'(issue_rd_tag), 32'd31);
        issue_ready = 1'b1;
        step();
        chk("t4_old_waits", 32'(issue_valid), 32'd0);
        cdb(1'b1, 6'd3, 32'h33);
        step();
        cdb(1'b0, 6'd0, 32'd0);
        chk("t4_old_valid", 32'(issue_valid), 32'd1);
        chk("t4_old_tag", 32'(issue_rd_tag), 32'd30);
        chk("t4_old_rs1", issue_rs1_data, 32'h33);
        step();
        chk("t4_empty", 32'(issue_valid), 32'd0);

        // Dispatch-time CDB bypass
        issue_ready = 1'b0;
        disp(1'b1, 4'h6, 6'd40, 32'd1, 6'd0, 1'b1, 32'd0, 6'd7, 1'b0);
        cdb(1'b1, 6'd7, 32'h55);
        step();
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        cdb(1'b0, 6'd0, 32'd0);
        chk("t5_valid", 32'(issue_valid), 32'd1);
        chk("t5_rd_tag", 32'(issue_rd_tag), 32'd40);
        chk("t5_rs2", issue_rs2_data, 32'h55);
        issue_ready = 1'b1;
        step();
        chk("t5_empty", 32'(issue_valid), 32'd0);

        // Asynchronous reset with three entries held
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(1'b1, 4'h2, 6'(50 + i), 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1);
            step();
        end
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        chk("t6_held", 32'(issue_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(issue_valid), 32'd0);
        chk("t6_rst_full", 32'(issueque_full_integer), 32'd0);
        chk("t6_rst_tag", 32'(issue_rd_tag), 32'd0);
        issue_ready = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t6_no_issue", 32'(issue_valid), 32'd0);
        // Count restarted from zero: full only after four more dispatches
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(1'b1, 4'h3, 6'(60 + i), 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
            step();
            if (i == 2) chk("t6_cnt_3", 32'(issueque_full_integer), 32'd0);
        end
        disp(1'b0, 4'h0, 6'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0);
        chk("t6_cnt_4", 32'(issueque_full_integer), 32'd1);
        chk("t6_head", 32'(issue_rd_tag), 32'd60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue_int.md
ISSUE_QUEUE_INT -- requirements
Module: issue_queue_int

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, number of entries; DATA_WIDTH, 32, operand width; TAG_WIDTH, 6, rename-tag width.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 dispatch_en_integer  in  1  dispatch request, one instruction per cycle.
REQ-006 dispatch_opcode  in  4  ALU operation code.
REQ-007 dispatch_rd_tag  in  TAG_WIDTH  destination tag.
REQ-008 dispatch_rs1_data / dispatch_rs2_data  in  DATA_WIDTH  operand values.
REQ-009 dispatch_rs1_tag / dispatch_rs2_tag  in  TAG_WIDTH  producer tags.
REQ-010 dispatch_rs1_valid / dispatch_rs2_valid  in  1  1 = operand data valid; 0 = await tag on CDB.
REQ-011 CDB_tag  in  TAG_WIDTH; CDB_valid  in  1; CDB_data  in  DATA_WIDTH  result broadcast.
REQ-012 issue_ready  in  1  integer execution unit can accept an instruction.
REQ-013 issueque_full_integer  out  1  no free entry.
REQ-014 issue_valid  out  1  issue_opcode  out  4  issue_rd_tag  out  TAG_WIDTH  issue_rs1_data, issue_rs2_data  out  DATA_WIDTH  selected instruction.

Function
REQ-015 Entries SHALL be held in age order, entry 0 oldest; a registered count (0..DEPTH) SHALL track occupancy.
REQ-016 Dispatch SHALL be accepted when dispatch_en_integer=1 and issueque_full_integer=0; the instruction SHALL be written into the first free slot after compaction on that edge.
REQ-017 dispatch_en_integer while issueque_full_integer=1 SHALL be ignored, with no state change.
REQ-018 issueque_full_integer SHALL equal (count==DEPTH), from registered state only; a same-cycle issue does not clear it.
REQ-019 An entry is ready when both operand-valid bits are 1; issue_valid SHALL be 1 when any entry is ready, combinationally from registered entries.
REQ-020 Selection SHALL pick the lowest-index (oldest) ready entry; issue_* outputs SHALL carry its fields.
REQ-021 Issue SHALL occur when issue_valid & issue_ready; the issued entry SHALL be removed and younger entries shifted down one slot on that edge.
REQ-022 Simultaneous issue and accepted dispatch SHALL leave count unchanged; the new entry lands at index count-1 after the shift.
REQ-023 When CDB_valid=1, every held operand with valid=0 and tag==CDB_tag SHALL capture CDB_data and set valid on that edge.
REQ-024 A dispatching operand with valid=0 whose tag matches a same-cycle valid CDB broadcast SHALL be written already valid with CDB_data.
REQ-025 Latency: an instruction dispatched ready at edge N SHALL be issuable in cycle N+1; an entry woken at edge N SHALL be issuable in cycle N+1.
REQ-026 issue_ready=0 SHALL hold all entries in place; wakeup and dispatch continue.
REQ-027 Opcode and tags SHALL pass unmodified; no arithmetic on data.

Reset
REQ-028 On reset assertion, count=0, all entry valid/operand-valid bits SHALL clear immediately, regardless of any operation in progress.
REQ-029 During and after reset until dispatch: issueque_full_integer=0, issue_valid=0, issue_opcode=0, issue_rd_tag=0, issue data=0.

Structure
REQ-030 A shared package SHALL hold TAG_WIDTH, the 4-bit opcode width, and the issue-queue entry record (busy, opcode, rd_tag, rs1/rs2 data, tag, valid).
REQ-031 One sub-module, iq_select, SHALL implement the DEPTH-wide oldest-first priority select and return index plus found flag.

Verification
REQ-032 Reset, then dispatch opcode 4'h1, rd_tag 6'd5, both operands valid (rs1=32'd10, rs2=32'd20), issue_ready=1 -> next cycle issue_valid=1, rd_tag 5, data 10/20; following cycle issue_valid=0.
REQ-033 Dispatch rs1_valid=0 tag 6'd9; later CDB_valid=1, CDB_tag 9, CDB_data 32'hDEAD -> issue_valid=1 one cycle later with issue_rs1_data=32'hDEAD.
REQ-034 issue_ready=0, dispatch 4 valid instructions -> issueque_full_integer=1 after 4th edge; 5th dispatch ignored; issue_ready=1 -> tags issue in dispatch order.
REQ-035 Entry 0 waiting on tag 3, entry 1 ready -> entry 1 issues first; after CDB tag 3, entry 0 issues.
REQ-036 Dispatch with rs2_valid=0 tag 7 in same cycle as CDB tag 7 data 32'h55 -> entry issuable next cycle with rs2 data 32'h55.
REQ-037 Assert reset with 3 entries held -> issue_valid and issueque_full_integer 0 immediately; no issue after release.
